// File: rtl/ica_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ica_pkg
// Purpose : Shared definitions for the FastICA iteration sequencer. Holds the
//           default weight width, the default iteration limit, the size of a
//           4x4 weight bank and the sequencer state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ica_pkg;

  localparam int ICA_DW       = 26;   // signed fixed-point weight width
  localparam int ICA_MAX_ITER = 100;  // default iteration limit
  localparam int ICA_NW       = 16;   // elements in a 4x4 matrix

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPD    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_ARM    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } ica_state_e;

endpackage
`default_nettype wire

// File: rtl/ica_wbank.sv
`default_nettype none
// ============================================================================
// Module  : ica_wbank
// Purpose : 16 x DW weight register bank with a single load enable. Contents
//           clear on reset and otherwise hold until the next load.
// Ports   : clk_i  - clock, rising edge
//           rst_i  - asynchronous active-high reset
//           ld_i   - load enable, captures d_i on the clock edge
//           d_i    - 16 packed weights, element 0 = row1/col1 .. 15 = row4/col4
//           q_o    - registered bank contents, same ordering as d_i
// Rev     : 1.0  initial release
// ============================================================================
module ica_wbank
  import ica_pkg::*;
#(
  parameter int DW = ICA_DW
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ld_i,
  input  logic [ICA_NW-1:0][DW-1:0]   d_i,
  output logic [ICA_NW-1:0][DW-1:0]   q_o
);

  logic [ICA_NW-1:0][DW-1:0] bank_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_q <= '0;
    end else if (ld_i) begin
      bank_q <= d_i;
    end
  end

  assign q_o = bank_q;

endmodule
`default_nettype wire

// File: rtl/ica_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ica_iter_ctrl
// Purpose : FastICA iteration sequencer. Starts a weight update, latches the
//           new matrix, launches the error/convergence stage, samples the
//           verdict and either iterates again or retires the final matrix.
// Ports   : clk_iter, rst_iter         - clock / async active-high reset
//           start, abort               - solve request / synchronous abort
//           upd_start, upd_done        - update-stage handshake
//           w_new11..w_new44           - updated weights (valid with upd_done)
//           wn11..wn44                 - latched weights to the error stage
//           en_error, error_busy       - error-stage launch / busy
//           isConverge, w11..w44       - error-stage verdict and w_ica
//           w_out11..w_out44           - final unmixing matrix
//           ica_busy, done             - activity flag / completion pulse
//           converged, timeout         - sticky end-of-solve reasons
//           iter_count                 - completed iterations
// Rev     : 1.0  initial release
// ============================================================================
module ica_iter_ctrl
  import ica_pkg::*;
#(
  parameter int DW       = ICA_DW,
  parameter int MAX_ITER = ICA_MAX_ITER,
  parameter int CNT_W    = 8
) (
  input  logic                    clk_iter,
  input  logic                    rst_iter,
  input  logic                    start,
  input  logic                    abort,
  output logic                    upd_start,
  input  logic                    upd_done,
  input  logic signed [DW-1:0]    w_new11, w_new12, w_new13, w_new14,
  input  logic signed [DW-1:0]    w_new21, w_new22, w_new23, w_new24,
  input  logic signed [DW-1:0]    w_new31, w_new32, w_new33, w_new34,
  input  logic signed [DW-1:0]    w_new41, w_new42, w_new43, w_new44,
  output logic signed [DW-1:0]    wn11, wn12, wn13, wn14,
  output logic signed [DW-1:0]    wn21, wn22, wn23, wn24,
  output logic signed [DW-1:0]    wn31, wn32, wn33, wn34,
  output logic signed [DW-1:0]    wn41, wn42, wn43, wn44,
  output logic                    en_error,
  input  logic                    error_busy,
  input  logic                    isConverge,
  input  logic signed [DW-1:0]    w11, w12, w13, w14,
  input  logic signed [DW-1:0]    w21, w22, w23, w24,
  input  logic signed [DW-1:0]    w31, w32, w33, w34,
  input  logic signed [DW-1:0]    w41, w42, w43, w44,
  output logic signed [DW-1:0]    w_out11, w_out12, w_out13, w_out14,
  output logic signed [DW-1:0]    w_out21, w_out22, w_out23, w_out24,
  output logic signed [DW-1:0]    w_out31, w_out32, w_out33, w_out34,
  output logic signed [DW-1:0]    w_out41, w_out42, w_out43, w_out44,
  output logic                    ica_busy,
  output logic                    done,
  output logic                    converged,
  output logic                    timeout,
  output logic [CNT_W-1:0]        iter_count
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAX_ITER - 1);

  ica_state_e       state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             conv_q, conv_d;
  logic             tout_q, tout_d;
  logic             verdict_q, verdict_d;
  logic             upd_start_q, upd_start_d;
  logic             en_error_q, en_error_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ld_wn, ld_wout;

  logic [ICA_NW-1:0][DW-1:0] w_new_pk, w_ica_pk, wn_pk, wout_pk;

  // Element 0 is row1/col1, element 15 is row4/col4.
  assign w_new_pk = {w_new44, w_new43, w_new42, w_new41, w_new34, w_new33, w_new32, w_new31,
                     w_new24, w_new23, w_new22, w_new21, w_new14, w_new13, w_new12, w_new11};
  assign w_ica_pk = {w44, w43, w42, w41, w34, w33, w32, w31,
                     w24, w23, w22, w21, w14, w13, w12, w11};

  always_ff @(posedge clk_iter or posedge rst_iter) begin
    if (rst_iter) begin
      state_q     <= ST_IDLE;
      iter_q      <= '0;
      conv_q      <= 1'b0;
      tout_q      <= 1'b0;
      verdict_q   <= 1'b0;
      upd_start_q <= 1'b0;
      en_error_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      conv_q      <= conv_d;
      tout_q      <= tout_d;
      verdict_q   <= verdict_d;
      upd_start_q <= upd_start_d;
      en_error_q  <= en_error_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    conv_d    = conv_q;
    tout_d    = tout_q;
    verdict_d = verdict_q;
    ld_wn     = 1'b0;
    ld_wout   = 1'b0;

    if (abort) begin
      // Abort wins over everything, including a same-cycle upd_done.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_UPD;
            iter_d  = '0;
            conv_d  = 1'b0;
            tout_d  = 1'b0;
          end
        end
        ST_UPD: begin
          if (upd_done) begin
            state_d = ST_LAUNCH;
            ld_wn   = 1'b1;
          end
        end
        ST_LAUNCH: state_d = ST_ARM;
        // Guard cycle: the error stage needs one cycle to raise busy.
        ST_ARM:    state_d = ST_WAIT;
        ST_WAIT: begin
          if (!error_busy) begin
            state_d   = ST_CHECK;
            // The verdict is only guaranteed as busy drops, so hold it here.
            verdict_d = isConverge;
          end
        end
        ST_CHECK: begin
          iter_d = iter_q + CNT_W'(1);
          if (verdict_q) begin
            ld_wout = 1'b1;
            conv_d  = 1'b1;
            state_d = ST_DONE;
          end else if (iter_q == LAST_ITER) begin
            ld_wout = 1'b1;
            tout_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_UPD;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered versions of the state being entered, so each
    // pulse lines up with the first cycle of its state.
    upd_start_d = (state_d == ST_UPD) && (state_q != ST_UPD);
    en_error_d  = (state_d == ST_LAUNCH);
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  ica_wbank #(.DW(DW)) u_wn_bank (
    .clk_i (clk_iter),
    .rst_i (rst_iter),
    .ld_i  (ld_wn),
    .d_i   (w_new_pk),
    .q_o   (wn_pk)
  );

  ica_wbank #(.DW(DW)) u_wout_bank (
    .clk_i (clk_iter),
    .rst_i (rst_iter),
    .ld_i  (ld_wout),
    .d_i   (w_ica_pk),
    .q_o   (wout_pk)
  );

  assign {wn44, wn43, wn42, wn41, wn34, wn33, wn32, wn31,
          wn24, wn23, wn22, wn21, wn14, wn13, wn12, wn11} = wn_pk;
  assign {w_out44, w_out43, w_out42, w_out41, w_out34, w_out33, w_out32, w_out31,
          w_out24, w_out23, w_out22, w_out21, w_out14, w_out13, w_out12, w_out11} = wout_pk;

  assign upd_start  = upd_start_q;
  assign en_error   = en_error_q;
  assign done       = done_q;
  assign ica_busy   = busy_q;
  assign converged  = conv_q;
  assign timeout    = tout_q;
  assign iter_count = iter_q;

endmodule
`default_nettype wire

// File: tb/tb_ica_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ica_iter_ctrl
// Purpose : Self-checking bench for ica_iter_ctrl (MAX_ITER = 3). Acts as the
//           update and error stages, scoreboards latched and final matrices,
//           and runs abort / reset / ignored-start corner sequences.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ica_iter_ctrl;

  localparam int DW   = 26;
  localparam int MAXI = 3;
  localparam int CW   = 8;
  localparam int NW   = 16;

  typedef logic [NW*DW-1:0] mat_t;

  typedef struct {
    int              upd_lat;   // cycles from upd_start to upd_done
    int              d;         // cycles from en_error to busy rising (<= 2)
    int              len;       // busy high length (0 = never busy)
    int              conv_it;   // converging iteration, 0 = never
    logic [DW-1:0]   a11;
    logic [DW-1:0]   a44;
    logic [DW-1:0]   fill;
    logic [DW-1:0]   wofs;      // w_ica = w_new + wofs
    bit              noise;     // start + stray upd_done during WAIT
    int              exp_iter;
    bit              exp_conv;
    bit              exp_tout;
  } vec_t;

  typedef struct {
    int  iter;
    bit  conv;
    bit  tout;
  } res_t;

  logic clk_iter = 1'b0, rst_iter = 1'b1, start = 1'b0, abort = 1'b0;
  logic upd_done = 1'b0, error_busy = 1'b0, isConverge = 1'b0;
  logic signed [DW-1:0] w_new [NW];
  logic signed [DW-1:0] w     [NW];
  logic signed [DW-1:0] wn_o  [NW];
  logic signed [DW-1:0] wout_o[NW];
  logic upd_start, en_error, ica_busy, done, converged, timeout;
  logic [CW-1:0] iter_count;

  int   total = 0;
  int   bad   = 0;
  mat_t q_wn[$];
  mat_t q_wout[$];
  res_t q_res[$];
  mat_t last_wout = '0;
  mat_t last_wn   = '0;
  vec_t vecs[6];

  always #5 clk_iter = ~clk_iter;

  ica_iter_ctrl #(.DW(DW), .MAX_ITER(MAXI), .CNT_W(CW)) dut (
    .clk_iter(clk_iter), .rst_iter(rst_iter), .start(start), .abort(abort),
    .upd_start(upd_start), .upd_done(upd_done),
    .w_new11(w_new[0]),  .w_new12(w_new[1]),  .w_new13(w_new[2]),  .w_new14(w_new[3]),
    .w_new21(w_new[4]),  .w_new22(w_new[5]),  .w_new23(w_new[6]),  .w_new24(w_new[7]),
    .w_new31(w_new[8]),  .w_new32(w_new[9]),  .w_new33(w_new[10]), .w_new34(w_new[11]),
    .w_new41(w_new[12]), .w_new42(w_new[13]), .w_new43(w_new[14]), .w_new44(w_new[15]),
    .wn11(wn_o[0]),  .wn12(wn_o[1]),  .wn13(wn_o[2]),  .wn14(wn_o[3]),
    .wn21(wn_o[4]),  .wn22(wn_o[5]),  .wn23(wn_o[6]),  .wn24(wn_o[7]),
    .wn31(wn_o[8]),  .wn32(wn_o[9]),  .wn33(wn_o[10]), .wn34(wn_o[11]),
    .wn41(wn_o[12]), .wn42(wn_o[13]), .wn43(wn_o[14]), .wn44(wn_o[15]),
    .en_error(en_error), .error_busy(error_busy), .isConverge(isConverge),
    .w11(w[0]),  .w12(w[1]),  .w13(w[2]),  .w14(w[3]),
    .w21(w[4]),  .w22(w[5]),  .w23(w[6]),  .w24(w[7]),
    .w31(w[8]),  .w32(w[9]),  .w33(w[10]), .w34(w[11]),
    .w41(w[12]), .w42(w[13]), .w43(w[14]), .w44(w[15]),
    .w_out11(wout_o[0]),  .w_out12(wout_o[1]),  .w_out13(wout_o[2]),  .w_out14(wout_o[3]),
    .w_out21(wout_o[4]),  .w_out22(wout_o[5]),  .w_out23(wout_o[6]),  .w_out24(wout_o[7]),
    .w_out31(wout_o[8]),  .w_out32(wout_o[9]),  .w_out33(wout_o[10]), .w_out34(wout_o[11]),
    .w_out41(wout_o[12]), .w_out42(wout_o[13]), .w_out43(wout_o[14]), .w_out44(wout_o[15]),
    .ica_busy(ica_busy), .done(done), .converged(converged), .timeout(timeout),
    .iter_count(iter_count)
  );

  function automatic mat_t pack(input logic signed [DW-1:0] a[NW]);
    mat_t m;
    m = '0;
    for (int i = 0; i < NW; i++) m[i*DW +: DW] = a[i];
    return m;
  endfunction

  // Weight pattern the update stage returns on iteration k.
  function automatic logic [DW-1:0] wpat(input vec_t v, input int k, input int i);
    if (i == 0)  return v.a11 + DW'(k);
    if (i == 15) return v.a44;
    return v.fill * DW'(i) + v.fill * DW'(k);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chkm(input string nm, input mat_t act, input mat_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Runs one complete solve, acting as both pipeline stages.
  task automatic run_vec(input vec_t v);
    int   eL, fall, k, exp_upd, exp_en, exp_done, upd_cnt, en_cnt, upd_wait;
    bit   pend, err_on, fin, last;
    mat_t m;
    res_t r;
    k = 0; exp_upd = 1; exp_en = -1; exp_done = -1; upd_cnt = 0; en_cnt = 0;
    upd_wait = 0; pend = 0; err_on = 0; fin = 0; eL = 0; fall = 0;
    q_res.push_back('{v.exp_iter, v.exp_conv, v.exp_tout});
    @(negedge clk_iter);
    start = 1'b1;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk_iter);
      start    = 1'b0;
      upd_done = 1'b0;
      if (upd_start) begin
        upd_cnt++;
        chk("upd_start_latency", cyc, exp_upd);
        pend = 1'b1;
        upd_wait = v.upd_lat;
      end
      if (pend) begin
        if (upd_wait == 0) begin
          for (int i = 0; i < NW; i++) w_new[i] = wpat(v, k, i);
          upd_done = 1'b1;
          q_wn.push_back(pack(w_new));
          exp_en = cyc + 1;
          pend = 1'b0;
        end else begin
          upd_wait--;
        end
      end
      if (en_error) begin
        en_cnt++;
        chk("en_error_latency", cyc, exp_en);
        if (q_wn.size() == 0) begin
          chk("en_error_unexpected", 1, 0);
        end else begin
          m = q_wn.pop_front();
          last_wn = m;
          chkm("wn_latch", pack(wn_o), m);
        end
        eL = cyc;
        err_on = 1'b1;
        last = (v.conv_it == k + 1) || (k == MAXI - 1);
        isConverge = (v.conv_it == k + 1);
        for (int i = 0; i < NW; i++) w[i] = wpat(v, k, i) + v.wofs;
        fall = (v.d + v.len > 2) ? eL + v.d + v.len : eL + 2;
        if (last) begin
          exp_done = fall + 2;
          q_wout.push_back(pack(w));
          last_wout = pack(w);
        end else begin
          exp_upd = fall + 2;
        end
        k++;
      end
      error_busy = err_on && (cyc >= eL + v.d) && (cyc < eL + v.d + v.len);
      if (v.noise && err_on && cyc == eL + 2) begin
        start    = 1'b1;
        upd_done = 1'b1;
        for (int i = 0; i < NW; i++) w_new[i] = 26'h1DEAD00 + DW'(i);
      end
      if (done) begin
        chk("done_latency", cyc, exp_done);
        r = q_res.pop_front();
        chk("iter_count", iter_count, r.iter);
        chk("converged", converged, r.conv);
        chk("timeout", timeout, r.tout);
        if (q_wout.size() == 0) chk("w_out_missing", 1, 0);
        else chkm("w_out", pack(wout_o), q_wout.pop_front());
        chkm("wn_hold", pack(wn_o), last_wn);
        chk("upd_start_count", upd_cnt, r.iter);
        chk("en_error_count", en_cnt, r.iter);
        chk("busy_in_done", ica_busy, 0);
        fin = 1'b1;
      end
    end
    if (!fin) chk("solve_cycle_budget", 0, 1);
    start = 1'b0; upd_done = 1'b0; error_busy = 1'b0;
    @(negedge clk_iter);
    chk("done_single_pulse", done, 0);
    chk("idle_after_done", ica_busy, 0);
  endtask

  // Drives start and one immediate update with the given values; returns in
  // the LAUNCH cycle.
  task automatic begin_solve(input logic [DW-1:0] base, output mat_t wn_exp);
    @(negedge clk_iter); start = 1'b1;
    @(negedge clk_iter); start = 1'b0;
    chk("seq_upd_start", upd_start, 1);
    for (int i = 0; i < NW; i++) w_new[i] = base + DW'(i);
    wn_exp = pack(w_new);
    upd_done = 1'b1;
    @(negedge clk_iter); upd_done = 1'b0;
    chk("seq_en_error", en_error, 1);
    error_busy = 1'b1;
  endtask

  initial begin
    mat_t expA, dummy;
    int   seen;
    for (int i = 0; i < NW; i++) begin w_new[i] = '0; w[i] = '0; end

    //          lat d len conv a11           a44           fill          wofs       nz it cv to
    vecs[0] = '{2, 2, 4, 1, 26'h0010000, 26'h0000000, 26'h0000000, 26'h0000000, 0, 1, 1, 0};
    vecs[1] = '{1, 2, 3, 0, 26'h0000123, 26'h2000000, 26'h0000011, 26'h0000007, 0, 3, 0, 1};
    vecs[2] = '{0, 2, 2, 2, 26'h0000000, 26'h3FFFFFF, 26'h3FFFFF0, 26'h0000100, 0, 2, 1, 0};
    vecs[3] = '{3, 2, 0, 1, 26'h0000055, 26'h0000001, 26'h0000003, 26'h0000000, 0, 1, 1, 0};
    vecs[4] = '{1, 1, 5, 3, 26'h0001000, 26'h3000000, 26'h0000101, 26'h0000003, 1, 3, 1, 0};
    vecs[5] = '{0, 2, 1, 0, 26'h3FFFF00, 26'h0000042, 26'h2AAAAAA, 26'h3FFFFFF, 1, 3, 0, 1};

    // Reset state
    repeat (3) @(negedge clk_iter);
    chk("rst_busy", ica_busy, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_flags", {converged, timeout, done, upd_start, en_error}, 0);
    chkm("rst_wn", pack(wn_o), '0);
    chkm("rst_wout", pack(wout_o), '0);
    rst_iter = 1'b0;

    for (int t = 0; t < 6; t++) run_vec(vecs[t]);

    // Abort while waiting on the error stage.
    begin_solve(26'h0ABC000, expA);
    @(negedge clk_iter);              // ARM
    @(negedge clk_iter); abort = 1'b1; // WAIT
    @(negedge clk_iter); abort = 1'b0;
    chk("abortA_idle", ica_busy, 0);
    chk("abortA_done", done, 0);
    chk("abortA_iter", iter_count, 0);
    chkm("abortA_wn", pack(wn_o), expA);
    chkm("abortA_wout", pack(wout_o), last_wout);
    seen = 0;
    repeat (4) begin @(negedge clk_iter); seen += int'(done); end
    chk("abortA_no_done", seen, 0);
    error_busy = 1'b0;

    // Abort together with upd_done: the update is dropped.
    @(negedge clk_iter); start = 1'b1;
    @(negedge clk_iter); start = 1'b0;
    chk("abortB_upd_start", upd_start, 1);
    for (int i = 0; i < NW; i++) w_new[i] = 26'h0123400 + DW'(i);
    upd_done = 1'b1; abort = 1'b1;
    @(negedge clk_iter); upd_done = 1'b0; abort = 1'b0;
    chk("abortB_idle", ica_busy, 0);
    chkm("abortB_wn", pack(wn_o), expA);
    seen = 0;
    repeat (4) begin @(negedge clk_iter); seen += int'(en_error) + int'(done); end
    chk("abortB_no_pulses", seen, 0);

    // Asynchronous reset mid-WAIT.
    begin_solve(26'h0F0F000, dummy);
    @(negedge clk_iter);
    @(negedge clk_iter);
    #1 rst_iter = 1'b1;
    #1;
    chk("rstC_busy", ica_busy, 0);
    chk("rstC_iter", iter_count, 0);
    chk("rstC_flags", {converged, timeout, done, upd_start, en_error}, 0);
    chkm("rstC_wn", pack(wn_o), '0);
    chkm("rstC_wout", pack(wout_o), '0);
    @(negedge clk_iter);
    rst_iter = 1'b0; error_busy = 1'b0;

    // Recovery after reset.
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
